// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one full-subtractor
// cell per clock with a registered borrow; start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: start is sampled on a rising edge only when busy is low (IDLE or
  // DONE); done is a one-cycle pulse in the cycle after results are loaded.
  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_ovf;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_br_next;
  logic             w_accept;
  logic             w_last;

  assign w_x       = r_sa[0];
  assign w_y       = r_sb[0];
  assign w_d       = w_x ^ w_y ^ r_br;
  assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_accept  = start && (r_state != S_RUN);
  assign w_last    = (r_state == S_RUN) && (r_cnt == LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (r_cnt == LAST) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_sr    <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
    end else if (w_accept) begin
      r_sa    <= a;
      r_sb    <= b;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (r_state == S_RUN) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_sr  <= {w_d, r_sr[WIDTH-1:1]};
      r_br  <= w_br_next;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Results are loaded only on the final bit so partial sums never appear on diff.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_last) begin
      r_diff   <= {w_d, r_sr[WIDTH-1:1]};
      r_borrow <= w_br_next;
      r_ovf    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a countdown of cycles left and the arithmetic result of a - b.
  int           m_left = 0;
  logic         m_done = 0;
  logic [W-1:0] m_diff = 0;
  logic         m_borrow = 0;
  logic         m_ovf = 0;
  logic [W-1:0] p_diff;
  logic         p_borrow;
  logic         p_ovf;

  always @(posedge clk) begin
    int sd;
    if (!rst_n) begin
      m_left = 0; m_done = 0; m_diff = 0; m_borrow = 0; m_ovf = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_diff = p_diff; m_borrow = p_borrow; m_ovf = p_ovf; m_done = 1;
        end
      end else if (start) begin
        m_left   = W;
        p_diff   = a - b;
        p_borrow = (a < b);
        sd       = int'($signed(a)) - int'($signed(b));
        p_ovf    = (sd > 127) || (sd < -128);
      end
    end
  end

  // Per-cycle compare of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy",   {31'd0, busy},   {31'd0, m_left > 0});
      check("cyc_done",   {31'd0, done},   {31'd0, m_done});
      check("cyc_diff",   {24'd0, diff},   {24'd0, m_diff});
      check("cyc_borrow", {31'd0, borrow}, {31'd0, m_borrow});
      check("cyc_ovf",    {31'd0, ovf},    {31'd0, m_ovf});
    end
  end

  // Driver: one pulsed start, then wait (bounded) for done and check literal results.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic [W-1:0] ed, input logic eb, input logic eo);
    int nb;
    bit got;
    @(negedge clk); a = xa; b = xb; start = 1'b1;
    @(negedge clk); start = 1'b0;
    nb = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (busy) nb++;
      if (done) got = 1;
      else @(negedge clk);
    end
    check("op_done_seen", {31'd0, got}, 32'd1);
    check("op_busy_cycles", nb, W);
    check("op_diff", {24'd0, diff}, {24'd0, ed});
    check("op_borrow", {31'd0, borrow}, {31'd0, eb});
    check("op_ovf", {31'd0, ovf}, {31'd0, eo});
  endtask

  initial begin
    int ndone;
    int k;
    logic [W-1:0] seen;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_flags", {30'd0, borrow, ovf}, 32'd0);
    cmp_en = 1;

    do_op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
    do_op(8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
    do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    do_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    do_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
    do_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    do_op(8'hFF, 8'h80, 8'h7F, 1'b0, 1'b0);

    // Start and operand changes during RUN are ignored.
    @(negedge clk); a = 8'h35; b = 8'h12; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0; a = 8'h77; b = 8'h99;
    ndone = 0; seen = '0;
    for (int i = 0; i < 14; i++) begin
      if (done) begin ndone++; seen = diff; end
      @(negedge clk);
    end
    check("run_ignore_ndone", ndone, 1);
    check("run_ignore_diff", {24'd0, seen}, 32'h23);

    // Back-to-back with start held high.
    @(negedge clk); a = 8'h10; b = 8'h01; start = 1'b1;
    k = 0;
    while (!done && k < 20) begin @(negedge clk); k++; end
    check("b2b_first_done", {31'd0, done}, 32'd1);
    check("b2b_first_diff", {24'd0, diff}, 32'h0F);
    a = 8'h01; b = 8'h10;
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 20);
    check("b2b_period", k, W + 1);
    check("b2b_second_diff", {24'd0, diff}, 32'hF1);
    check("b2b_second_borrow", {31'd0, borrow}, 32'd1);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a run.
    a = 8'h35; b = 8'h12; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_diff", {24'd0, diff}, 32'd0);
    check("mid_rst_flags", {30'd0, borrow, ovf}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("mid_rst_no_done", ndone, 0);
    do_op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `diff = a - b` one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the subtraction counterpart of the team's adder cells. It sits beside them in the arithmetic datapath where area matters more than latency, and uses a start/busy/done handshake.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is 2 and up.
- `clk`  in  1  the single clock; all state changes occur on its rising edge.
- `rst_n`  in  1  synchronous reset, active-low, sampled on the rising edge of `clk`.
- `start`  in  1  request to begin a subtraction; sampled only when the block is not busy.
- `a`  in  WIDTH  minuend; captured on the edge that accepts `start`.
- `b`  in  WIDTH  subtrahend; captured on the same edge as `a`.
- `busy`  out  1  high while a subtraction is in progress.
- `done`  out  1  single-cycle pulse marking that the results have been updated.
- `diff`  out  WIDTH  result `a - b` modulo 2^WIDTH; holds its value until the next completion.
- `borrow`  out  1  unsigned borrow, equal to 1 when `a < b` (unsigned); holds like `diff`.
- `ovf`  out  1  signed overflow of `a - b`; holds like `diff`.

## Operation
- FSM has three states: IDLE, RUN, DONE.
  - IDLE to RUN: `start` = 1.
  - RUN to DONE: after the WIDTH-th bit is processed.
  - DONE to RUN: `start` = 1.
  - DONE to IDLE: `start` = 0.
- On an accepted start:
  - `a` and `b` are loaded into shift registers `sa` and `sb`.
  - Internal borrow `br` is cleared to 0.
  - Bit counter is cleared to 0; its width is $clog2(WIDTH+1).
- Each RUN cycle, with x = `sa[0]` and y = `sb[0]`:
  - d = x ^ y ^ br.
  - br_next = (~x & y) | (~(x ^ y) & br).
  - `sa` and `sb` shift right by one.
  - d shifts into the MSB of result register `sr`.
  - Counter increments.
- On the last RUN cycle (counter = WIDTH-1):
  - `diff` is loaded with the final `sr`, including the last d.
  - `borrow` is loaded with br_next.
  - `ovf` is loaded with (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the captured operand MSBs.
- `diff`, `borrow` and `ovf` change only at completion or reset; intermediate bits are never visible on them.
- `busy` = (state == RUN).
- `done` = (state == DONE).
- `start` in RUN is ignored; no queueing and no restart.
- `start` in DONE is accepted (back-to-back operation). The held results stay valid through that DONE cycle.
- Reset (`rst_n` = 0 at an edge), in any state including mid-RUN:
  - State goes to IDLE; the partial operation is discarded.
  - `busy`, `done`, `diff`, `borrow`, `ovf` and all internal registers are 0.
- Reset has priority over `start` in the same cycle.

## Timing
- Start is accepted at rising edge E0.
- `busy` is high from just after E0 until just after E0+WIDTH (WIDTH cycles).
- At E0+WIDTH, `diff`, `borrow` and `ovf` update and `done` rises. `done` falls at E0+WIDTH+1 unless the FSM re-enters DONE.
- Latency from start to done is exactly WIDTH cycles.
- Back-to-back throughput: with `start` held at 1, one result every WIDTH+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Operands are sampled only at the accepting edge. Later changes to `a` or `b` have no effect on the result.

## Test plan
- **Positive result, no flags.** WIDTH=8, `a`=0x35, `b`=0x12, `start` pulsed for 1 cycle → `done` 8 cycles later, `diff`=0x23, `borrow`=0, `ovf`=0; `busy` high for exactly 8 cycles.
- **Unsigned borrow.** `a`=0x12, `b`=0x35 → `diff`=0xDD, `borrow`=1, `ovf`=0.
- **Signed overflow and zero result.**
  - `a`=0x80, `b`=0x01 → `diff`=0x7F, `borrow`=0, `ovf`=1.
  - `a`=0x00, `b`=0x00 → `diff`=0x00, all flags 0.
  - `a`=0x00, `b`=0xFF → `diff`=0x01, `borrow`=1, `ovf`=0.
- **Start and operand changes during RUN.** Start with 0x35 − 0x12. At cycle 3, pulse `start` with `a`=0xFF, `b`=0xFF, and change `a`/`b` during RUN → result is still 0x23, with a single `done` at cycle 8.
- **Back-to-back operation.** Hold `start`=1 with 0x10 − 0x01, then switch `a`/`b` to 0x01 − 0x10 in the DONE cycle → `diff`=0x0F, `done` pulse, then 9 cycles later `diff`=0xF1 with `borrow`=1.
- **Reset mid-operation.** Drive `rst_n`=0 for 1 cycle at RUN cycle 4 → next cycle `busy`=0, `done`=0, `diff`=0, flags 0, and no `done` appears. A new start then completes normally in 8 cycles.
